// File: rtl/memio_pkg.sv
// Shared types and defaults for the memory/IO bridge.
package memio_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [31:0] IO_BASE_DEF   = 32'hFFFFFC00;
  localparam logic [31:0] IO_STRIDE_DEF = 32'h10;

  // Channel index width; a single channel still gets one index bit.
  function automatic int ch_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/memio_decode.sv
// Combinational IO address decode: byte address -> {legal, channel index, one-hot select}.
module memio_decode
  import memio_pkg::*;
#(
  parameter int          N_IO      = 4,
  parameter logic [31:0] IO_BASE   = IO_BASE_DEF,
  parameter logic [31:0] IO_STRIDE = IO_STRIDE_DEF,
  parameter int          CH_W      = ch_width(N_IO)
) (
  input  logic [31:0]     addr,
  output logic            legal,
  output logic [CH_W-1:0] ch,
  output logic [N_IO-1:0] onehot
);

  localparam int SH = $clog2(IO_STRIDE);

  logic [31:0] ch_full;

  // Full-width channel number so that addresses far above the window are rejected.
  assign ch_full = (addr - IO_BASE) >> SH;
  assign legal   = (addr >= IO_BASE) && (ch_full < 32'(N_IO));
  assign ch      = ch_full[CH_W-1:0];

  for (genvar k = 0; k < N_IO; k++) begin : g_onehot
    assign onehot[k] = legal && (ch == CH_W'(k));
  end

endmodule

// File: rtl/memio_bridge.sv
// Memory/IO bridge: same-cycle memory pass-through, IO channel decode with wait-state FSM and stall.
// Optional saturating error counter port err_cnt enabled by defining MEMIO_ERR_CNT_EN.
//
//   state | meaning
//   ------+--------------------------------------------------------------
//   IDLE  | memory pass-through; accepts a legal IO request (stall at T0)
//   WAIT  | chip select held, strobes asserted, wait counter running
//   DONE  | select released, captured read data returned, stall low
module memio_bridge
  import memio_pkg::*;
#(
  parameter int          DATA_W    = 32,
  parameter int          IO_W      = 16,
  parameter int          N_IO      = 4,
  parameter logic [31:0] IO_BASE   = IO_BASE_DEF,
  parameter logic [31:0] IO_STRIDE = IO_STRIDE_DEF,
  parameter int          WAIT_CYC  = 2
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 m_read,
  input  logic                 m_write,
  input  logic                 io_read,
  input  logic                 io_write,
  input  logic [31:0]          addr_in,
  input  logic [DATA_W-1:0]    r_rdata,
  input  logic [DATA_W-1:0]    m_rdata,
  input  logic [N_IO*IO_W-1:0] io_rdata,
  output logic [31:0]          addr_out,
  output logic [DATA_W-1:0]    write_data,
  output logic [DATA_W-1:0]    r_wdata,
  output logic [N_IO-1:0]      io_cs,
  output logic                 io_we,
  output logic                 io_re,
  output logic                 stall,
  output logic                 err
`ifdef MEMIO_ERR_CNT_EN
  ,output logic [7:0]          err_cnt
`endif
);

  localparam int CH_W  = ch_width(N_IO);
  localparam int CNT_W = $clog2(WAIT_CYC + 1);

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic [31:0]       lat_addr;
  logic [CH_W-1:0]   lat_ch;
  logic [N_IO-1:0]   lat_cs;
  logic [DATA_W-1:0] lat_data;
  logic              lat_wr;
  logic [DATA_W-1:0] cap;

  logic              dec_legal;
  logic [CH_W-1:0]   dec_ch;
  logic [N_IO-1:0]   dec_onehot;

  logic              any_m, any_io, illegal, accept, last_wait;
  logic [IO_W-1:0]   ch_data [N_IO];

  memio_decode #(
    .N_IO      (N_IO),
    .IO_BASE   (IO_BASE),
    .IO_STRIDE (IO_STRIDE),
    .CH_W      (CH_W)
  ) u_decode (
    .addr   (addr_in),
    .legal  (dec_legal),
    .ch     (dec_ch),
    .onehot (dec_onehot)
  );

  for (genvar k = 0; k < N_IO; k++) begin : g_ch_data
    assign ch_data[k] = io_rdata[k*IO_W +: IO_W];
  end

  assign any_m     = m_read | m_write;
  assign any_io    = io_read | io_write;
  assign illegal   = (m_read & m_write) | (io_read & io_write) | (any_m & any_io)
                   | (any_io & ~dec_legal);
  // Combinational paths are gated by reset_n so stall/err drop the moment reset asserts.
  assign accept    = reset_n && (state == IDLE) && any_io && !illegal;
  assign last_wait = (state == WAIT) && (cnt == CNT_W'(1));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = WAIT;
      WAIT:    if (cnt == CNT_W'(1)) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt      <= '0;
      lat_addr <= '0;
      lat_ch   <= '0;
      lat_cs   <= '0;
      lat_data <= '0;
      lat_wr   <= 1'b0;
      cap      <= '0;
    end else begin
      if (accept) begin
        cnt      <= CNT_W'(WAIT_CYC);
        lat_addr <= addr_in;
        lat_ch   <= dec_ch;
        lat_cs   <= dec_onehot;
        lat_data <= r_rdata;
        lat_wr   <= io_write;
      end else if (state == WAIT) begin
        cnt <= cnt - CNT_W'(1);
      end
      if (last_wait) begin
        cap <= DATA_W'(ch_data[lat_ch]);
      end
    end
  end

  always_comb begin
    addr_out   = addr_in;
    write_data = '0;
    r_wdata    = '0;
    io_cs      = '0;
    io_we      = 1'b0;
    io_re      = 1'b0;
    stall      = 1'b0;
    err        = 1'b0;
    case (state)
      IDLE: begin
        if (reset_n && illegal) begin
          err = 1'b1;
        end else if (accept) begin
          stall = 1'b1;
        end else if (reset_n) begin
          if (m_write) write_data = r_rdata;
          if (m_read)  r_wdata    = m_rdata;
        end
      end
      WAIT: begin
        addr_out   = lat_addr;
        write_data = lat_data;
        io_cs      = lat_cs;
        io_we      = lat_wr;
        io_re      = !lat_wr;
        stall      = 1'b1;
      end
      DONE: begin
        addr_out = lat_addr;
        if (!lat_wr) r_wdata = cap;
      end
      default: ;
    endcase
  end

`ifdef MEMIO_ERR_CNT_EN
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      err_cnt <= 8'h00;
    end else if (err && (err_cnt != 8'hFF)) begin
      err_cnt <= err_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_memio_bridge.sv
// Directed self-checking bench for memio_bridge (default parameters, WAIT_CYC = 2).
module tb_memio_bridge;

  localparam int DATA_W = 32;
  localparam int IO_W   = 16;
  localparam int N_IO   = 4;

  logic                 clock = 1'b0;
  logic                 reset_n = 1'b0;
  logic                 m_read, m_write, io_read, io_write;
  logic [31:0]          addr_in;
  logic [DATA_W-1:0]    r_rdata, m_rdata;
  logic [N_IO*IO_W-1:0] io_rdata;
  logic [31:0]          addr_out;
  logic [DATA_W-1:0]    write_data, r_wdata;
  logic [N_IO-1:0]      io_cs;
  logic                 io_we, io_re, stall, err;
`ifdef MEMIO_ERR_CNT_EN
  logic [7:0]           err_cnt;
  int                   exp_err_cnt = 0;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  memio_bridge u_dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .m_read     (m_read),
    .m_write    (m_write),
    .io_read    (io_read),
    .io_write   (io_write),
    .addr_in    (addr_in),
    .r_rdata    (r_rdata),
    .m_rdata    (m_rdata),
    .io_rdata   (io_rdata),
    .addr_out   (addr_out),
    .write_data (write_data),
    .r_wdata    (r_wdata),
    .io_cs      (io_cs),
    .io_we      (io_we),
    .io_re      (io_re),
    .stall      (stall),
    .err        (err)
`ifdef MEMIO_ERR_CNT_EN
    ,.err_cnt   (err_cnt)
`endif
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    m_read   = 1'b0;
    m_write  = 1'b0;
    io_read  = 1'b0;
    io_write = 1'b0;
    addr_in  = 32'h0;
    r_rdata  = '0;
    m_rdata  = '0;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // One-cycle illegal request: err high, nothing selected, no stall; then back to idle.
  task automatic illegal_access(input string tag, input logic mr, input logic mw,
                                input logic ir, input logic iw, input logic [31:0] a);
    m_read = mr; m_write = mw; io_read = ir; io_write = iw; addr_in = a;
    #1;
    check({tag, "_err"},   err,   1'b1);
    check({tag, "_cs"},    io_cs, 4'b0000);
    check({tag, "_stall"}, stall, 1'b0);
    check({tag, "_rdata"}, r_wdata, 32'h0);
    tick();
    idle_inputs();
    #1;
    check({tag, "_err_clr"}, err, 1'b0);
`ifdef MEMIO_ERR_CNT_EN
    exp_err_cnt = (exp_err_cnt < 255) ? exp_err_cnt + 1 : 255;
    check({tag, "_err_cnt"}, err_cnt, 8'(exp_err_cnt));
`endif
  endtask

  initial begin
    idle_inputs();
    io_rdata = 64'h1111_BEEF_2222_3333;
    repeat (3) @(posedge clock);
    #1;
    check("rst_cs",    io_cs,      4'b0000);
    check("rst_stall", stall,      1'b0);
    check("rst_err",   err,        1'b0);
    check("rst_wdata", write_data, 32'h0);
    check("rst_rdata", r_wdata,    32'h0);
`ifdef MEMIO_ERR_CNT_EN
    check("rst_err_cnt", err_cnt, 8'h00);
`endif
    reset_n = 1'b1;
    tick();

    // memory read / write pass-through
    m_read = 1'b1; addr_in = 32'h100; m_rdata = 32'h12345678;
    #1;
    check("mrd_rdata", r_wdata,  32'h12345678);
    check("mrd_stall", stall,    1'b0);
    check("mrd_cs",    io_cs,    4'b0000);
    check("mrd_addr",  addr_out, 32'h100);
    tick();
    idle_inputs();
    m_write = 1'b1; addr_in = 32'h204; r_rdata = 32'hCAFEF00D;
    #1;
    check("mwr_wdata", write_data, 32'hCAFEF00D);
    check("mwr_rdata", r_wdata,    32'h0);
    check("mwr_addr",  addr_out,   32'h204);
    tick();
    idle_inputs();

    // IO read channel 2
    io_read = 1'b1; addr_in = 32'hFFFFFC20;
    #1;
    check("ird_t0_stall", stall, 1'b1);
    check("ird_t0_cs",    io_cs, 4'b0000);
    for (int i = 0; i < 2; i++) begin
      tick();
      check("ird_wait_cs",    io_cs,    4'b0100);
      check("ird_wait_re",    io_re,    1'b1);
      check("ird_wait_we",    io_we,    1'b0);
      check("ird_wait_stall", stall,    1'b1);
      check("ird_wait_addr",  addr_out, 32'hFFFFFC20);
    end
    tick();
    check("ird_done_stall", stall,   1'b0);
    check("ird_done_cs",    io_cs,   4'b0000);
    check("ird_done_data",  r_wdata, 32'h0000BEEF);
    check("ird_done_err",   err,     1'b0);
    idle_inputs();
    tick();
    check("ird_idle_rdata", r_wdata, 32'h0);
    check("ird_idle_stall", stall,   1'b0);

    // IO write channel 3 (top boundary channel)
    io_write = 1'b1; addr_in = 32'hFFFFFC30; r_rdata = 32'h0000A5A5;
    #1;
    check("iwr_t0_stall", stall, 1'b1);
    for (int i = 0; i < 2; i++) begin
      tick();
      check("iwr_wait_cs",    io_cs,      4'b1000);
      check("iwr_wait_we",    io_we,      1'b1);
      check("iwr_wait_re",    io_re,      1'b0);
      check("iwr_wait_wdata", write_data, 32'h0000A5A5);
      check("iwr_wait_stall", stall,      1'b1);
    end
    tick();
    check("iwr_done_cs",    io_cs,   4'b0000);
    check("iwr_done_stall", stall,   1'b0);
    check("iwr_done_rdata", r_wdata, 32'h0);
    idle_inputs();
    tick();
    check("iwr_idle_cs", io_cs, 4'b0000);

    // illegal accesses
    illegal_access("oor_ch4",  1'b0, 1'b0, 1'b1, 1'b0, 32'hFFFFFC40);
    illegal_access("below",    1'b0, 1'b0, 1'b1, 1'b0, 32'hFFFFFBFC);
    illegal_access("io_rw",    1'b0, 1'b0, 1'b1, 1'b1, 32'hFFFFFC00);
    illegal_access("m_and_io", 1'b1, 1'b0, 1'b1, 1'b0, 32'hFFFFFC10);
    illegal_access("m_rw",     1'b1, 1'b1, 1'b0, 1'b0, 32'h00000100);

    // reset during WAIT abandons the access
    io_read = 1'b1; addr_in = 32'hFFFFFC10;
    tick();
    check("rstw_cs_before", io_cs, 4'b0010);
    reset_n = 1'b0;
    #1;
    check("rstw_cs",    io_cs, 4'b0000);
    check("rstw_stall", stall, 1'b0);
    check("rstw_re",    io_re, 1'b0);
    check("rstw_err",   err,   1'b0);
    idle_inputs();
    tick();
    reset_n = 1'b1;
`ifdef MEMIO_ERR_CNT_EN
    exp_err_cnt = 0;
    check("rstw_err_cnt", err_cnt, 8'h00);
`endif
    tick();
    io_read = 1'b1; addr_in = 32'hFFFFFC00;
    #1;
    check("post_t0_stall", stall, 1'b1);
    tick();
    check("post_wait_cs", io_cs, 4'b0001);
    tick();
    tick();
    check("post_done_data",  r_wdata, 32'h00003333);
    check("post_done_stall", stall,   1'b0);
    idle_inputs();
    tick();

`ifdef MEMIO_ERR_CNT_EN
    // saturation of the error counter
    for (int i = 0; i < 300; i++) begin
      io_read = 1'b1; io_write = 1'b1; addr_in = 32'hFFFFFC00;
      tick();
    end
    idle_inputs();
    #1;
    check("sat_err_cnt", err_cnt, 8'hFF);
    check("sat_err_clr", err,     1'b0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
